ir_command_scheduler: RTL and testbench
=======================================

// Module: ir_command_scheduler
// PURPOSE
//   Upstream stage of the IR transmitter. Turns mouse movement reports into a 4-bit car
//   direction command and issues a periodic one-cycle SEND_PACKET strobe. COMMAND is held
//   stable for the full packet duration so the transmitter samples a clean value.
//   Sits between the PS/2 mouse receiver and the transmitter's COMMAND/SEND_PACKET inputs.
// PARAMETERS
//   SEND_PERIOD   5_000_000   cycles between send ticks (100 ms @ 50 MHz)
//   HOLD_CYCLES   2_000_000   cycles COMMAND frozen after strobe; must be < SEND_PERIOD-2
//   DEADZONE      4           |delta| <= DEADZONE counts as no movement on that axis
//   IDLE_TIMEOUT  25_000_000  cycles without qualifying movement before pending cmd -> 0000
// PORTS
//   CLK           in   1  system clock, 50 MHz
//   RESET         in   1  asynchronous, active-low reset
//   ENABLE        in   1  level; 0 stops new packets
//   MOUSE_DX      in   8  signed two's-complement X delta (+ = right)
//   MOUSE_DY      in   8  signed two's-complement Y delta (+ = forward)
//   MOUSE_VALID   in   1  one-cycle strobe; DX/DY valid this cycle
//   COMMAND       out  4  {FWD,BACK,LEFT,RIGHT} = bits [3:0], to transmitter
//   SEND_PACKET   out  1  one-cycle strobe, to transmitter
//   PACKET_COUNT  out  8  packets issued, wraps 255 -> 0
// BEHAVIOUR
//   Reset (RESET=0, async): COMMAND=0, SEND_PACKET=0, PACKET_COUNT=0, pending=0,
//     all counters 0, FSM=IDLE. Reset mid-packet clears outputs immediately.
//   Capture (on MOUSE_VALID): sign-extend deltas to 9 bits before comparing.
//     RIGHT=dx>DEADZONE, LEFT=dx<-DEADZONE, FWD=dy>DEADZONE, BACK=dy<-DEADZONE.
//     Both axes inside deadzone: pending unchanged.
//     Otherwise pending <= the new 4-bit value, and the idle counter is cleared.
//     LEFT&RIGHT or FWD&BACK are never both set. -128 decodes as LEFT/BACK.
//   Idle: the counter counts while pending!=0. On reaching IDLE_TIMEOUT-1, pending <= 0000.
//     MOUSE_VALID in the same cycle takes priority over the timeout.
//   Period counter: runs 0..SEND_PERIOD-1 while FSM!=IDLE and is held at 0 in IDLE.
//     tick = (count==SEND_PERIOD-1).
//   FSM:
//     IDLE   : ENABLE=1 -> WAIT
//     WAIT   : ENABLE=0 -> IDLE; tick -> LOAD
//     LOAD   : COMMAND <= pending; -> SEND
//     SEND   : SEND_PACKET=1 for exactly this cycle; PACKET_COUNT++; -> HOLD
//     HOLD   : count HOLD_CYCLES; COMMAND frozen; done -> (ENABLE ? WAIT : IDLE)
//   Latency: tick in cycle T -> COMMAND updated T+1 -> SEND_PACKET high T+2.
//     COMMAND is therefore stable >=1 cycle before the strobe.
//   ENABLE falling in LOAD/SEND/HOLD does not abort; the in-flight packet completes.
//   A pending of 0000 is still sent (explicit stop packet).
//   pending may change during HOLD; it takes effect only at the next LOAD.
//   COMMAND keeps its last value in IDLE/WAIT; SEND_PACKET is 0 outside SEND.
// STRUCTURE
//   Shared package/include: FSM state encodings (IDLE, WAIT, LOAD, SEND, HOLD) and
//     command bit indices CMD_RIGHT=0, CMD_LEFT=1, CMD_BACK=2, CMD_FWD=3 (shared with
//     the transmitter and car-side decoder).
//   Sub-module: ir_mouse_direction_decoder holds the deadzone compare, pending register
//     and idle timeout, and outputs pending[3:0].
//   Top level holds the period counter, FSM, hold counter and PACKET_COUNT.
// TESTING (bench params: SEND_PERIOD=20, HOLD_CYCLES=8, DEADZONE=4, IDLE_TIMEOUT=50)
//   1. Assert reset, then ENABLE=1, no mouse activity.
//      -> first SEND_PACKET 21 cycles after WAIT entry, COMMAND=0000;
//      -> strobe exactly 1 cycle wide, PACKET_COUNT=1.
//   2. VALID with DX=+10, DY=-20.
//      -> COMMAND=0101 at the next strobe, stable from the LOAD cycle through the end of HOLD.
//   3. VALID DX=+4, DY=-4 after a previous 1000.
//      -> pending stays 1000;
//      -> VALID DX=-128, DY=0 -> 0010.
//   4. VALID DX=+10, then 50 quiet cycles.
//      -> pending=0000, next packet COMMAND=0000;
//      -> VALID on the timeout cycle -> new value kept.
//   5. ENABLE drops in the SEND cycle.
//      -> HOLD completes, FSM -> IDLE, no further strobes;
//      -> ENABLE=1 -> strobes resume.
//   6. RESET low mid-HOLD.
//      -> COMMAND=0, PACKET_COUNT=0 immediately;
//      -> 256 packets -> PACKET_COUNT wraps to 0.

Source files
------------

// File: rtl/ir_command_scheduler_pkg.sv
// Shared definitions for the IR command scheduler, transmitter and car-side decoder.
// Holds FSM state encodings, command bit positions and a counter-width helper.
package ir_command_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam int CMD_RIGHT = 0;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_BACK  = 2;
    localparam int CMD_FWD   = 3;

    // Bits needed for a counter spanning 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ir_mouse_direction_decoder.sv
// Turns mouse deltas into a pending 4-bit direction command.
// Movement inside the deadzone is ignored; a stale command decays to stop.
module ir_mouse_direction_decoder
    import ir_command_scheduler_pkg::*;
#(
    parameter int DEADZONE     = 4,
    parameter int IDLE_TIMEOUT = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    input  logic       mouse_valid,
    output logic [3:0] pending
);

    localparam int IW = cnt_width(IDLE_TIMEOUT);
    localparam logic signed [8:0] DZ_POS = 9'(DEADZONE);
    localparam logic signed [8:0] DZ_NEG = -DZ_POS;

    logic signed [8:0] dx_ext;
    logic signed [8:0] dy_ext;
    logic [3:0]        dir;
    logic [IW-1:0]     idle_cnt;
    logic              timeout;

    assign dx_ext = {mouse_dx[7], mouse_dx};
    assign dy_ext = {mouse_dy[7], mouse_dy};

    always_comb begin
        dir            = 4'b0000;
        dir[CMD_RIGHT] = dx_ext > DZ_POS;
        dir[CMD_LEFT]  = dx_ext < DZ_NEG;
        dir[CMD_FWD]   = dy_ext > DZ_POS;
        dir[CMD_BACK]  = dy_ext < DZ_NEG;
    end

    assign timeout = (pending != 4'b0000) &&
                     (idle_cnt == IW'(IDLE_TIMEOUT - 1));

    // Fresh movement outranks a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 4'b0000;
            idle_cnt <= '0;
        end else if (mouse_valid && dir != 4'b0000) begin
            pending  <= dir;
            idle_cnt <= '0;
        end else if (timeout) begin
            pending  <= 4'b0000;
            idle_cnt <= '0;
        end else if (pending != 4'b0000) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

endmodule

// File: rtl/ir_command_scheduler.sv
// Periodic packet scheduler feeding the IR transmitter.
// Latches the pending direction, strobes SEND_PACKET and freezes COMMAND while sending.
module ir_command_scheduler
    import ir_command_scheduler_pkg::*;
#(
    parameter int SEND_PERIOD  = 5_000_000,
    parameter int HOLD_CYCLES  = 2_000_000,
    parameter int DEADZONE     = 4,
    parameter int IDLE_TIMEOUT = 25_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] MOUSE_DX,
    input  logic [7:0] MOUSE_DY,
    input  logic       MOUSE_VALID,
    output logic [3:0] COMMAND,
    output logic       SEND_PACKET,
    output logic [7:0] PACKET_COUNT
);

    localparam int PW = cnt_width(SEND_PERIOD);
    localparam int HW = cnt_width(HOLD_CYCLES);

    state_t        state;
    logic [3:0]    pending;
    logic [PW-1:0] period_cnt;
    logic [HW-1:0] hold_cnt;
    logic          tick;

    ir_mouse_direction_decoder #(
        .DEADZONE    (DEADZONE),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_decoder (
        .clk        (CLK),
        .rst_n      (RESET),
        .mouse_dx   (MOUSE_DX),
        .mouse_dy   (MOUSE_DY),
        .mouse_valid(MOUSE_VALID),
        .pending    (pending)
    );

    assign tick = (period_cnt == PW'(SEND_PERIOD - 1));

    // Keeps running through LOAD/SEND/HOLD so packets stay on a fixed cadence.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            period_cnt <= '0;
        end else if (state == ST_IDLE || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            COMMAND      <= 4'b0000;
            SEND_PACKET  <= 1'b0;
            PACKET_COUNT <= 8'd0;
            hold_cnt     <= '0;
        end else begin
            SEND_PACKET <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ENABLE) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!ENABLE) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        state   <= ST_LOAD;
                        COMMAND <= pending;
                    end
                end
                ST_LOAD: begin
                    state        <= ST_SEND;
                    SEND_PACKET  <= 1'b1;
                    PACKET_COUNT <= PACKET_COUNT + 8'd1;
                end
                ST_SEND: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                end
                ST_HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state <= ENABLE ? ST_WAIT : ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_command_scheduler.sv
// Scoreboard bench for ir_command_scheduler with short periods.
// Stimulus queues expected packets; a monitor checks each SEND_PACKET strobe.
module tb_ir_command_scheduler;

    logic       CLK;
    logic       RESET;
    logic       ENABLE;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       MOUSE_VALID;
    logic [3:0] COMMAND;
    logic       SEND_PACKET;
    logic [7:0] PACKET_COUNT;

    ir_command_scheduler #(
        .SEND_PERIOD (20),
        .HOLD_CYCLES (8),
        .DEADZONE    (4),
        .IDLE_TIMEOUT(50)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .MOUSE_DX    (MOUSE_DX),
        .MOUSE_DY    (MOUSE_DY),
        .MOUSE_VALID (MOUSE_VALID),
        .COMMAND     (COMMAND),
        .SEND_PACKET (SEND_PACKET),
        .PACKET_COUNT(PACKET_COUNT)
    );

    typedef struct {
        logic [3:0] cmd;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_strobes = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [7:0] n);
        exp_t e;
        e.cmd = c;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe pops one expected packet.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (SEND_PACKET) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe actual=%0d required=none",
                             COMMAND);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_command", COMMAND, e.cmd);
                    @(negedge CLK);
                    chk("strobe_width", SEND_PACKET, 0);
                    chk("packet_count", PACKET_COUNT, e.cnt);
                    chk("command_hold", COMMAND, e.cmd);
                end
            end
        end
    end

    task automatic wait_strobe(input int limit, output int at,
                               output logic [3:0] pre_cmd);
        logic [3:0] prev;
        bit got;
        got = 0;
        prev = COMMAND;
        at = -1;
        pre_cmd = 4'b0000;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge CLK);
            if (SEND_PACKET) begin
                got = 1;
                at = cyc;
                pre_cmd = prev;
            end else begin
                prev = COMMAND;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL strobe_timeout actual=none required=strobe");
        end
    endtask

    task automatic mouse(input logic [7:0] dx, input logic [7:0] dy);
        MOUSE_DX = dx;
        MOUSE_DY = dy;
        MOUSE_VALID = 1'b1;
        @(negedge CLK);
        MOUSE_VALID = 1'b0;
    endtask

    initial begin
        int t0;
        int at;
        int seen;
        logic [3:0] pre;

        RESET = 1'b0;
        ENABLE = 1'b0;
        MOUSE_DX = 8'd0;
        MOUSE_DY = 8'd0;
        MOUSE_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_command", COMMAND, 0);
        chk("reset_send", SEND_PACKET, 0);
        chk("reset_count", PACKET_COUNT, 0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        // 1: idle mouse, first packet is a stop packet
        push(4'b0000, 8'd1);
        ENABLE = 1'b1;
        t0 = cyc;
        wait_strobe(40, at, pre);
        chk("first_latency", at, t0 + 22);

        // 2: right+back, then a change during HOLD
        mouse(8'd10, 8'hEC);
        push(4'b0101, 8'd2);
        wait_strobe(40, at, pre);
        chk("load_command", pre, 4'b0101);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("hold_stable", COMMAND, 4'b0101);
            if (i == 0) begin
                MOUSE_DX = 8'd0;
                MOUSE_DY = 8'd10;
                MOUSE_VALID = 1'b1;
            end else begin
                MOUSE_VALID = 1'b0;
            end
        end
        push(4'b1000, 8'd3);
        wait_strobe(40, at, pre);

        // 3: deadzone edge, then -128 decodes as LEFT
        mouse(8'd4, 8'hFC);
        push(4'b1000, 8'd4);
        wait_strobe(40, at, pre);
        mouse(8'h80, 8'd0);
        push(4'b0010, 8'd5);
        wait_strobe(40, at, pre);

        // 4: idle timeout, then VALID on the timeout cycle
        push(4'b0001, 8'd6);
        push(4'b0001, 8'd7);
        push(4'b0000, 8'd8);
        mouse(8'd10, 8'd0);
        for (int k = 0; k < 3; k++) wait_strobe(40, at, pre);
        push(4'b0001, 8'd9);
        push(4'b0001, 8'd10);
        push(4'b1000, 8'd11);
        mouse(8'd10, 8'd0);
        repeat (49) @(negedge CLK);
        mouse(8'd0, 8'd10);
        wait_strobe(40, at, pre);

        // 5: ENABLE drops in SEND cycle
        ENABLE = 1'b0;
        seen = n_strobes;
        repeat (60) @(negedge CLK);
        chk("disabled_strobes", n_strobes, seen);
        chk("idle_keeps_command", COMMAND, 4'b1000);
        mouse(8'd0, 8'd10);
        push(4'b1000, 8'd12);
        ENABLE = 1'b1;
        t0 = cyc;
        wait_strobe(40, at, pre);
        chk("resume_latency", at, t0 + 22);

        // 6: reset mid-HOLD, then count wrap
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midhold_reset_command", COMMAND, 0);
        chk("midhold_reset_count", PACKET_COUNT, 0);
        chk("midhold_reset_send", SEND_PACKET, 0);
        repeat (2) @(negedge CLK);
        for (int n = 1; n <= 256; n++) push(4'b0000, 8'(n));
        RESET = 1'b1;
        for (int n = 0; n < 256; n++) wait_strobe(40, at, pre);
        @(negedge CLK);
        chk("wrap_count", PACKET_COUNT, 0);
        ENABLE = 1'b0;
        repeat (40) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
